// File: rtl/core_hazard_pipe_if.sv
// Issue-side bundle for the hazard/forwarding controller: decode fields and
// pipeline controls in, stall/forward/kill decisions and perf counters out.
interface core_hazard_pipe_if #(
  parameter int unsigned REG_W = 5,
  parameter int unsigned CNT_W = 16
);
  logic             iss_val_in;
  logic [REG_W-1:0] iss_rs1_in;
  logic [REG_W-1:0] iss_rs2_in;
  logic             iss_use_rs1_in;
  logic             iss_use_rs2_in;
  logic [REG_W-1:0] iss_rd_in;
  logic             iss_we_in;
  logic             iss_load_in;
  logic             hold_in;
  logic             flush_in;
  logic             iss_stall_out;
  logic [2:0]       fwd_rs1_sel_out;
  logic [2:0]       fwd_rs2_sel_out;
  logic             kill_out;
  logic [CNT_W-1:0] stall_cnt_out;
  logic [CNT_W-1:0] flush_cnt_out;

  modport master (
    output iss_val_in, iss_rs1_in, iss_rs2_in, iss_use_rs1_in, iss_use_rs2_in,
    output iss_rd_in, iss_we_in, iss_load_in, hold_in, flush_in,
    input  iss_stall_out, fwd_rs1_sel_out, fwd_rs2_sel_out, kill_out,
    input  stall_cnt_out, flush_cnt_out
  );

  modport slave (
    input  iss_val_in, iss_rs1_in, iss_rs2_in, iss_use_rs1_in, iss_use_rs2_in,
    input  iss_rd_in, iss_we_in, iss_load_in, hold_in, flush_in,
    output iss_stall_out, fwd_rs1_sel_out, fwd_rs2_sel_out, kill_out,
    output stall_cnt_out, flush_cnt_out
  );
endinterface

// File: rtl/core_hazard_pipe.sv
// Hazard and forwarding controller: tracks rd/we/load of every in-flight
// instruction from EXE (stage 1) to WB (stage DEPTH) and derives stall/forward/kill.
module core_hazard_pipe #(
  parameter int unsigned DEPTH       = 3,
  parameter int unsigned LOAD_STAGE  = 3,
  parameter int unsigned KILL_STAGES = 1,
  parameter int unsigned REG_W       = 5,
  parameter int unsigned CNT_W       = 16
) (
  input logic              clk,
  input logic              rst_n,
  core_hazard_pipe_if.slave bus
);

  logic [DEPTH:1]   val_q, val_d, we_q, we_d, ld_q, ld_d;
  logic [REG_W-1:0] rd_q [DEPTH:1];
  logic [REG_W-1:0] rd_d [DEPTH:1];
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  logic [2:0] sel1, sel2;
  logic       lu1, lu2, hit1, hit2, stall, issue;

  // Only the youngest match counts; a not-yet-ready load blocks any older match.
  always_comb begin
    sel1 = '0;
    sel2 = '0;
    lu1  = 1'b0;
    lu2  = 1'b0;
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int unsigned k = 1; k <= DEPTH; k++) begin
      if (!hit1 && bus.iss_use_rs1_in && bus.iss_rs1_in != '0 && val_q[k] && we_q[k] &&
          rd_q[k] == bus.iss_rs1_in) begin
        hit1 = 1'b1;
        if (!ld_q[k] || k >= LOAD_STAGE) sel1 = 3'(k);
        else                             lu1  = 1'b1;
      end
      if (!hit2 && bus.iss_use_rs2_in && bus.iss_rs2_in != '0 && val_q[k] && we_q[k] &&
          rd_q[k] == bus.iss_rs2_in) begin
        hit2 = 1'b1;
        if (!ld_q[k] || k >= LOAD_STAGE) sel2 = 3'(k);
        else                             lu2  = 1'b1;
      end
    end
  end

  assign stall = bus.hold_in | (bus.iss_val_in & (lu1 | lu2));
  assign issue = bus.iss_val_in & ~stall & ~bus.flush_in;

  always_comb begin
    val_d = val_q;
    we_d  = we_q;
    ld_d  = ld_q;
    rd_d  = rd_q;
    if (!bus.hold_in) begin
      for (int unsigned k = 2; k <= DEPTH; k++) begin
        val_d[k] = val_q[k-1];
        we_d[k]  = we_q[k-1];
        ld_d[k]  = ld_q[k-1];
        rd_d[k]  = rd_q[k-1];
      end
      val_d[1] = issue;
      we_d[1]  = issue & bus.iss_we_in;
      ld_d[1]  = issue & bus.iss_load_in;
      rd_d[1]  = issue ? bus.iss_rd_in : '0;
    end
    // Flush clears the youngest stages after the shift, even under hold.
    if (bus.flush_in) begin
      for (int unsigned k = 1; k <= KILL_STAGES; k++) val_d[k] = 1'b0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (bus.iss_val_in && stall && !bus.flush_in && stall_cnt_q != '1) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (bus.flush_in && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      val_q       <= '0;
      we_q        <= '0;
      ld_q        <= '0;
      rd_q        <= '{default: '0};
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      val_q       <= val_d;
      we_q        <= we_d;
      ld_q        <= ld_d;
      rd_q        <= rd_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.iss_stall_out   = stall;
  assign bus.fwd_rs1_sel_out = sel1;
  assign bus.fwd_rs2_sel_out = sel2;
  assign bus.kill_out        = bus.flush_in;
  assign bus.stall_cnt_out   = stall_cnt_q;
  assign bus.flush_cnt_out   = flush_cnt_q;

endmodule

// File: tb/tb_core_hazard_pipe.sv
// Random plus directed bench for core_hazard_pipe; a list-of-instructions model
// predicts each cycle's outputs into a scoreboard that a negedge monitor drains.
module tb_core_hazard_pipe;
  localparam int unsigned DEPTH       = 3;
  localparam int unsigned LOAD_STAGE  = 3;
  localparam int unsigned KILL_STAGES = 1;
  localparam int unsigned REG_W       = 5;
  localparam int unsigned CNT_W       = 4;
  localparam int          MAXC        = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  core_hazard_pipe_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();

  core_hazard_pipe #(
    .DEPTH      (DEPTH),
    .LOAD_STAGE (LOAD_STAGE),
    .KILL_STAGES(KILL_STAGES),
    .REG_W      (REG_W),
    .CNT_W      (CNT_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {int age; int rd; bit we; bit ld;} ent_t;
  typedef struct {bit stall; int s1; int s2; bit kill; int sc; int fc;} exp_t;

  ent_t pipe[$];
  exp_t sbq[$];
  int   m_sc, m_fc;
  bit   known = 1'b0;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  function automatic int sat(input int x);
    return (x >= MAXC) ? MAXC : x + 1;
  endfunction

  // Youngest in-flight writer of rs decides; an unready load means stall.
  function automatic void fwd(input int rs, input bit u, output int sel, output bit lu);
    int best;
    bit bld;
    best = DEPTH + 1;
    bld  = 1'b0;
    sel  = 0;
    lu   = 1'b0;
    if (!u || rs == 0) return;
    foreach (pipe[i]) begin
      if (pipe[i].we && pipe[i].rd == rs && pipe[i].age < best) begin
        best = pipe[i].age;
        bld  = pipe[i].ld;
      end
    end
    if (best <= DEPTH) begin
      if (!bld || best >= LOAD_STAGE) sel = best;
      else                            lu  = 1'b1;
    end
  endfunction

  task automatic step(input bit v, input int r1, input int r2, input bit u1, input bit u2,
                      input int rd, input bit we, input bit ld, input bit hold, input bit fl,
                      input bit rn);
    int   s1, s2;
    bit   l1, l2, stall;
    ent_t e;
    ent_t nxt[$];
    rst_n              = rn;
    bus.iss_val_in     = v;
    bus.iss_rs1_in     = r1[REG_W-1:0];
    bus.iss_rs2_in     = r2[REG_W-1:0];
    bus.iss_use_rs1_in = u1;
    bus.iss_use_rs2_in = u2;
    bus.iss_rd_in      = rd[REG_W-1:0];
    bus.iss_we_in      = we;
    bus.iss_load_in    = ld;
    bus.hold_in        = hold;
    bus.flush_in       = fl;
    fwd(r1, u1, s1, l1);
    fwd(r2, u2, s2, l2);
    stall = hold | (v & (l1 | l2));
    if (known) sbq.push_back('{stall, s1, s2, fl, m_sc, m_fc});
    @(posedge clk);
    if (!rn) begin
      pipe.delete();
      m_sc  = 0;
      m_fc  = 0;
      known = 1'b1;
    end else begin
      if (v && stall && !fl) m_sc = sat(m_sc);
      if (fl) m_fc = sat(m_fc);
      foreach (pipe[i]) begin
        e = pipe[i];
        if (!hold) e.age++;
        if (e.age <= DEPTH && !(fl && e.age <= KILL_STAGES)) nxt.push_back(e);
      end
      if (v && !stall && !fl) nxt.push_back('{1, rd, we, ld});
      pipe = nxt;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("iss_stall", int'(bus.iss_stall_out), int'(e.stall));
        chk("fwd_rs1", int'(bus.fwd_rs1_sel_out), e.s1);
        chk("fwd_rs2", int'(bus.fwd_rs2_sel_out), e.s2);
        chk("kill", int'(bus.kill_out), int'(e.kill));
        chk("stall_cnt", int'(bus.stall_cnt_out), e.sc);
        chk("flush_cnt", int'(bus.flush_cnt_out), e.fc);
      end
    end
  end

  initial begin : driver
    rst_n              = 1'b0;
    bus.iss_val_in     = 1'b0;
    bus.iss_rs1_in     = '0;
    bus.iss_rs2_in     = '0;
    bus.iss_use_rs1_in = 1'b0;
    bus.iss_use_rs2_in = 1'b0;
    bus.iss_rd_in      = '0;
    bus.iss_we_in      = 1'b0;
    bus.iss_load_in    = 1'b0;
    bus.hold_in        = 1'b0;
    bus.flush_in       = 1'b0;
    @(posedge clk);
    #1;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(1);
    // add x5 followed by readers at distance 1..4
    step(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 1);
    for (int d = 1; d <= 4; d++) step(1, 5, 0, 1, 0, 9, 0, 0, 0, 0, 1);
    idle(3);
    // lw x7 then an rs2 reader: two stall cycles, then forward from stage 3
    step(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 0, 7, 0, 1, 9, 0, 0, 0, 0, 1);
    idle(3);
    // x0 writer and unused rs2
    step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
    step(1, 0, 0, 1, 0, 4, 1, 0, 0, 0, 1);
    step(1, 0, 4, 0, 0, 9, 0, 0, 0, 0, 1);
    idle(3);
    // add x3 older, lw x3 younger: youngest wins and stalls
    step(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 1);
    step(1, 3, 0, 1, 0, 9, 0, 0, 0, 0, 1);
    // flush with load-use pending, then observe survivors
    step(1, 3, 0, 1, 0, 9, 0, 0, 0, 1, 1);
    step(1, 3, 3, 1, 1, 9, 0, 0, 0, 0, 1);
    idle(3);
    // hold freezes state; stall counter saturates
    step(1, 0, 0, 0, 0, 6, 1, 0, 0, 0, 1);
    for (int i = 0; i < 20; i++) step(1, 6, 6, 1, 1, 9, 0, 0, 1, 0, 1);
    step(1, 6, 6, 1, 1, 9, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) < 7, $urandom_range(0, 3), $urandom_range(0, 3),
           $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3),
           $urandom_range(0, 4) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 11) == 0, $urandom_range(0, 199) != 0);
    end
    @(negedge clk);
    #1;
    chk("scoreboard_drained", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/core_hazard_pipe.md
Name: core_hazard_pipe

Overview:
- Parametrised hazard and forwarding controller for the Selen integer pipeline; replaces the fixed three-stage hazard control.
- Tracks the destination register, write-enable and load flag of every in-flight instruction in a DEPTH-entry shift register, stage 1 = EXE through stage DEPTH = WB.
- From that state it generates issue stall, per-source forwarding selects and flush kills.
- Also keeps saturating stall and flush counters for performance monitoring.

Parameters:
DEPTH, 3, number of tracked stages after decode (min 2, max 7)
LOAD_STAGE, 3, first stage index whose entry holds valid load data (1..DEPTH)
KILL_STAGES, 1, number of youngest stages (1..DEPTH-1) cleared by flush_in
REG_W, 5, register index width
CNT_W, 16, performance counter width

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
iss_val_in  in  1  decode holds a valid instruction
iss_rs1_in  in  REG_W  source 1 index
iss_rs2_in  in  REG_W  source 2 index
iss_use_rs1_in  in  1  instruction reads rs1
iss_use_rs2_in  in  1  instruction reads rs2
iss_rd_in  in  REG_W  destination index
iss_we_in  in  1  instruction writes register file
iss_load_in  in  1  instruction is a load
hold_in  in  1  external freeze (l1i/l1d not acked)
flush_in  in  1  taken branch/jump resolved in EXE
iss_stall_out  out  1  decode must not advance
fwd_rs1_sel_out  out  3  0 = register file, k = stage k result
fwd_rs2_sel_out  out  3  as above for rs2
kill_out  out  1  decode/IF register must be killed this cycle
stall_cnt_out  out  CNT_W  cycles with iss_stall_out=1 and iss_val_in=1
flush_cnt_out  out  CNT_W  number of flushes

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-low, on rst_n. While rst_n=0 at a rising edge: all stage valids, rd, we, load fields and both counters clear to 0.
- Outputs after reset: fwd sels 0, kill_out 0, iss_stall_out = hold_in.
- Stage entry k holds {val, rd, we, load}.
- Match(k, rs): val && we && rd == rs && rs != 0 && the matching use bit is set.
- Ready(k): !load || k >= LOAD_STAGE.
- Forwarding select, per source: take the youngest matching stage, i.e. the lowest k.
  - If Ready, sel = k.
  - If not Ready, sel = 0 and a load-use stall is raised. An older match is never used.
  - If there is no match, sel = 0.
  - Combinational, zero latency.
- iss_stall_out = hold_in | (iss_val_in & load-use on either source).
- Advance rule: if !hold_in, stage[k] <= stage[k-1] for k = 2..DEPTH, and stage DEPTH retires.
- Stage 1 loading:
  - Takes the issue fields when iss_val_in && !iss_stall_out && !flush_in.
  - Otherwise takes a bubble (val=0).
  - A load-use stall therefore inserts exactly one bubble per cycle.
- hold_in=1: every stage keeps its value. No issue, no retire.
- flush_in=1:
  - Stages 1..KILL_STAGES valids cleared at the edge, and kill_out=1 in the same cycle.
  - Issue is blocked that cycle.
  - Stages above KILL_STAGES behave per hold_in/advance.
  - Flush overrides hold for the killed stages.
- Flush and load-use in the same cycle: flush wins. The stalled instruction is killed via kill_out and the counter is not incremented for that cycle.
- Counters:
  - stall_cnt increments when iss_val_in && iss_stall_out && !flush_in.
  - flush_cnt increments on each flush_in cycle.
  - Both saturate at 2^CNT_W-1; they do not wrap.
- Reset mid-operation: all in-flight entries are discarded with no retire side-effects, and the next cycle behaves as post-reset.
- Sel encodings above DEPTH never appear. The 3-bit sel width covers DEPTH ≤ 7.

Test Plan:
1. Defaults. Issue add x5 (we), then next cycle issue a use of rs1=x5 -> fwd_rs1_sel_out=1, no stall. One cycle later, with a bubble between, a reuse -> sel=2. At distance 3 -> sel=3. At distance 4 -> sel=0.
2. Load-use. Issue lw x7, then immediately a use of rs2=x7 -> iss_stall_out=1 for 2 cycles with sel=0, then sel=3 and no stall. stall_cnt_out=2.
3. x0 and unused sources. Issue a write to x0, then rs1=0 -> sel=0, no stall. A match on rs2 with iss_use_rs2_in=0 -> sel=0.
4. Youngest priority. add x3 in stage 2 and lw x3 in stage 1, then a use of x3 -> stall, even though stage 2 would be ready.
5. Flush. Assert flush_in while a valid entry is in stage 1 and a load-use is pending -> kill_out=1, stage 1 valid=0 next cycle, stage 2 keeps the older entry. flush_cnt_out=1 and stall_cnt_out unchanged.
6. Hold and saturation. hold_in for 5 cycles -> entries frozen and sels stable. With CNT_W=2, 5 stall cycles -> stall_cnt_out=3. Drop rst_n for one edge mid-run -> all sels 0 and counters 0.
